seleccionar_barcos_jugadores: RTL
=================================

Name: seleccionar_barcos_jugadores

Overview:
Parametrised multi-player ship-count selector for the Battleship game logic. Each player in turn enters a ship count on a shared input and confirms it with a button. The block checks the value against a configurable range, stores one count per player and supports undoing the last entry. When every player has a valid count it raises a ready flag for the placement stage.

Parameters:
NUM_JUGADORES, 2, number of players selecting in turn (legal: >=1)
ANCHO, 3, bit width of a ship count
MIN_BARCOS, 1, smallest accepted count (legal: >=1)
MAX_BARCOS, 5, largest accepted count (legal: MIN_BARCOS <= MAX_BARCOS <= 2**ANCHO-1)

Ports:
clk  input  1  system clock; all state updates on its rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
cantidadBarcosSeleccionar  input  ANCHO  candidate ship count, shared by all players
botonSeleccionar  input  1  confirm button, level, already synchronised to clk
botonCancelar  input  1  undo button, level, already synchronised to clk
cantidadBarcosSeleccionada  output  NUM_JUGADORES*ANCHO  packed per-player counts; player j is in bits [j*ANCHO +: ANCHO]
jugadorActual  output  JW  index of the player now selecting; JW = max(1, $clog2(NUM_JUGADORES))
seleccionInvalida  output  1  one-cycle pulse: confirm was pressed with an out-of-range value
seleccionListo  output  1  level: all players hold valid counts

Behaviour:
- Reset (reset=0, asynchronous) sets all outputs and all state to 0: counts, jugadorActual, seleccionInvalida, seleccionListo, the state register and the previous-button registers.
- Button detection:
  - Both buttons are edge-detected with one registered previous value each.
  - An event is input=1 while the previous value=0.
  - Holding a button produces exactly one event.
  - Previous-value registers update every cycle in every state.
- FSM states:
  - SELECCION (reset state). Index j = jugadorActual.
  - LISTO.
- SELECCION, confirm event:
  - Value in range [MIN_BARCOS, MAX_BARCOS]: store it in slot j on that edge. The output is visible from that edge onward, so it has a 1-cycle registered latency from the sampled press.
  - If j < NUM_JUGADORES-1, j increments. If j = NUM_JUGADORES-1, go to LISTO; j stays at NUM_JUGADORES-1; seleccionListo becomes 1 on the same edge.
  - Value out of range (including 0): no store, j unchanged, seleccionInvalida=1 for exactly the next cycle.
- SELECCION, cancel event:
  - j > 0: clear slot j-1 to 0 and decrement j.
  - j = 0: no-op.
- LISTO:
  - Confirm events are ignored, with no invalid pulse.
  - Cancel event: clear slot NUM_JUGADORES-1, seleccionListo becomes 0, return to SELECCION with j = NUM_JUGADORES-1.
- Confirm and cancel events in the same cycle: cancel wins; the confirm is discarded with no invalid pulse.
- seleccionInvalida is registered and is 0 in every cycle not described above.
- Stored counts are never modified except by store, cancel or reset.
- Range comparison is unsigned at width ANCHO.
- NUM_JUGADORES = 1: a valid confirm goes straight to LISTO; jugadorActual stays 0.
- Reset asserted mid-selection discards all counts immediately, without waiting for a clock edge.

Optional Feature:
Macro IGUALAR_CANTIDAD_EN.
- Defined:
  - Only player 0 selects.
  - A valid confirm in SELECCION writes the value into all NUM_JUGADORES slots on one edge and goes straight to LISTO.
  - jugadorActual stays 0.
  - Cancel in LISTO clears all slots and returns to SELECCION with j=0.
  - Cancel in SELECCION is a no-op.
- Undefined: per-player sequential behaviour as specified above.

Test Plan:
- Reset then release, defaults, input=3 -> all outputs 0; after one confirm press, slot0=3, jugadorActual=1, seleccionListo=0.
- Confirm 3, then confirm 5 -> slot0=3, slot1=5, seleccionListo=1 on the second accept edge; further confirms with value 2 change nothing.
- Confirm with value 0, then with value 6 -> two 1-cycle seleccionInvalida pulses, counts stay 0, jugadorActual=0.
- Hold botonSeleccionar high for 10 cycles with value 4 -> only slot0=4, jugadorActual=1; slot1 unchanged.
- In LISTO (3,5): cancel -> slot1=0, seleccionListo=0, jugadorActual=1; cancel again -> slot0=0, j=0; confirm and cancel in the same cycle -> only the cancel takes effect.
- Drop reset asynchronously between clock edges with slot0=2 -> outputs 0 before the next clk edge; with IGUALAR_CANTIDAD_EN defined, confirm 4 -> both slots=4, seleccionListo=1.

Source files
------------

// File: rtl/seleccionar_barcos_jugadores.sv
// Per-player ship-count selection with range check, undo and ready flag; 1-cycle registered latency, no backpressure.
// IGUALAR_CANTIDAD_EN: player 0's confirmed count is copied to every player in one step.
module seleccionar_barcos_jugadores #(
    parameter int NUM_JUGADORES = 2,
    parameter int ANCHO         = 3,
    parameter int MIN_BARCOS    = 1,
    parameter int MAX_BARCOS    = 5,
    localparam int JW           = (NUM_JUGADORES > 1) ? $clog2(NUM_JUGADORES) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [ANCHO-1:0]               cantidadBarcosSeleccionar,
    input  logic                           botonSeleccionar,
    input  logic                           botonCancelar,
    output logic [NUM_JUGADORES*ANCHO-1:0] cantidadBarcosSeleccionada,
    output logic [JW-1:0]                  jugadorActual,
    output logic                           seleccionInvalida,
    output logic                           seleccionListo
);

    localparam logic [ANCHO-1:0] MIN_W   = ANCHO'(MIN_BARCOS);
    localparam logic [ANCHO-1:0] MAX_W   = ANCHO'(MAX_BARCOS);
    localparam logic [JW-1:0]    ULTIMO  = JW'(NUM_JUGADORES - 1);
    localparam int               BASE_UL = (NUM_JUGADORES - 1) * ANCHO;

    typedef enum logic {SELECCION = 1'b0, LISTO = 1'b1} estado_t;

    estado_t                        estado_q, estado_d;
    logic [NUM_JUGADORES*ANCHO-1:0] cuentas_q, cuentas_d;
    logic [JW-1:0]                  jugador_q, jugador_d;
    logic                           invalida_q, invalida_d;
    logic                           listo_q, listo_d;
    logic                           sel_prev_q, can_prev_q;

    logic evento_sel, evento_can, en_rango;

    assign evento_sel = botonSeleccionar & ~sel_prev_q;
    assign evento_can = botonCancelar & ~can_prev_q;
    assign en_rango   = (cantidadBarcosSeleccionar >= MIN_W) && (cantidadBarcosSeleccionar <= MAX_W);

    always_comb begin
        estado_d   = estado_q;
        cuentas_d  = cuentas_q;
        jugador_d  = jugador_q;
        listo_d    = listo_q;
        invalida_d = 1'b0;
        if (estado_q == SELECCION) begin
            // Cancel has priority; a simultaneous confirm is dropped silently.
            if (evento_can) begin
`ifndef IGUALAR_CANTIDAD_EN
                if (jugador_q != '0) begin
                    for (int j = 0; j < NUM_JUGADORES; j++) begin
                        if (j == int'(jugador_q) - 1) cuentas_d[j*ANCHO +: ANCHO] = '0;
                    end
                    jugador_d = jugador_q - 1'b1;
                end
`endif
            end else if (evento_sel) begin
                if (en_rango) begin
`ifdef IGUALAR_CANTIDAD_EN
                    for (int j = 0; j < NUM_JUGADORES; j++) begin
                        cuentas_d[j*ANCHO +: ANCHO] = cantidadBarcosSeleccionar;
                    end
                    estado_d = LISTO;
                    listo_d  = 1'b1;
`else
                    for (int j = 0; j < NUM_JUGADORES; j++) begin
                        if (j == int'(jugador_q)) cuentas_d[j*ANCHO +: ANCHO] = cantidadBarcosSeleccionar;
                    end
                    if (jugador_q == ULTIMO) begin
                        estado_d = LISTO;
                        listo_d  = 1'b1;
                    end else begin
                        jugador_d = jugador_q + 1'b1;
                    end
`endif
                end else begin
                    invalida_d = 1'b1;
                end
            end
        end else if (evento_can) begin
`ifdef IGUALAR_CANTIDAD_EN
            cuentas_d = '0;
            jugador_d = '0;
`else
            cuentas_d[BASE_UL +: ANCHO] = '0;
            jugador_d = ULTIMO;
`endif
            listo_d  = 1'b0;
            estado_d = SELECCION;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_q   <= SELECCION;
            cuentas_q  <= '0;
            jugador_q  <= '0;
            invalida_q <= 1'b0;
            listo_q    <= 1'b0;
            sel_prev_q <= 1'b0;
            can_prev_q <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            cuentas_q  <= cuentas_d;
            jugador_q  <= jugador_d;
            invalida_q <= invalida_d;
            listo_q    <= listo_d;
            sel_prev_q <= botonSeleccionar;
            can_prev_q <= botonCancelar;
        end
    end

    assign cantidadBarcosSeleccionada = cuentas_q;
    assign jugadorActual              = jugador_q;
    assign seleccionInvalida          = invalida_q;
    assign seleccionListo             = listo_q;

endmodule
